// File: rtl/stack_seq.sv
// Multi-cycle stack engine: pushes the return PC for CALL/IRQ entry and pops it for RET/RETI,
// stepping SP through the I/O register file and driving the data-RAM port one byte per cycle.
module stack_seq #(
    parameter bit pc22b = 1'b0
) (
    input  logic        cp2,
    input  logic        ireset,
    input  logic        cp2en,
    input  logic        start_call,
    input  logic        start_irq,
    input  logic        start_ret,
    input  logic        start_reti,
    input  logic [21:0] pc_in,
    input  logic [7:0]  spl_in,
    input  logic [7:0]  sph_in,
    input  logic [7:0]  ram_din,
    output logic        sp_en,
    output logic        sp_ndown_up,
    output logic [15:0] ram_adr,
    output logic [7:0]  ram_dout,
    output logic        ram_we,
    output logic        ram_re,
    output logic [21:0] pc_out,
    output logic        pc_load,
    output logic        sreg_i_wr_en,
    output logic        sreg_i_val,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] LAST = pc22b ? 2'd2 : 2'd1;

    typedef enum logic [2:0] {IDLE, PUSH, POP, CAPT, DONE} state_t;
    typedef enum logic [1:0] {OP_CALL, OP_IRQ, OP_RET, OP_RETI} op_t;

    state_t      state;
    op_t         op;
    logic [1:0]  cnt;
    logic [21:0] pc_lat;
    logic [13:0] pc_sh;
    logic [21:0] pc_q;
    logic [15:0] sp;

    assign sp = {sph_in, spl_in};

    function automatic logic [7:0] push_byte(input logic [21:0] pc, input logic [1:0] idx);
        case (idx)
            2'd0:    push_byte = pc[7:0];
            2'd1:    push_byte = pc[15:8];
            default: push_byte = {2'b00, pc[21:16]};
        endcase
    endfunction

    function automatic logic [21:0] assemble(input logic [13:0] hi, input logic [7:0] lo);
        assemble = pc22b ? {hi, lo} : {6'b0, hi[7:0], lo};
    endfunction

    always_ff @(posedge cp2 or negedge ireset) begin
        if (!ireset) begin
            state  <= IDLE;
            op     <= OP_CALL;
            cnt    <= 2'd0;
            pc_lat <= 22'd0;
            pc_sh  <= 14'd0;
            pc_q   <= 22'd0;
        end else if (cp2en) begin
            case (state)
                IDLE: begin
                    cnt   <= 2'd0;
                    pc_sh <= 14'd0;
                    if (start_irq) begin
                        op     <= OP_IRQ;
                        pc_lat <= pc22b ? pc_in : {6'b0, pc_in[15:0]};
                        state  <= PUSH;
                    end else if (start_call) begin
                        op     <= OP_CALL;
                        pc_lat <= pc22b ? pc_in : {6'b0, pc_in[15:0]};
                        state  <= PUSH;
                    end else if (start_reti) begin
                        op    <= OP_RETI;
                        state <= POP;
                    end else if (start_ret) begin
                        op    <= OP_RET;
                        state <= POP;
                    end
                end
                PUSH: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == LAST)
                        state <= DONE;
                end
                POP: begin
                    // Read data trails its issue by one cycle, so issue 0 has nothing to capture yet.
                    if (cnt != 2'd0)
                        pc_sh <= {pc_sh[5:0], ram_din};
                    cnt <= cnt + 2'd1;
                    if (cnt == LAST)
                        state <= CAPT;
                end
                CAPT: begin
                    pc_q  <= assemble(pc_sh, ram_din);
                    state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = (state != IDLE);
        sp_en        = ((state == PUSH) || (state == POP)) && cp2en;
        sp_ndown_up  = (state == POP);
        ram_we       = (state == PUSH) && cp2en;
        ram_re       = (state == POP) && cp2en;
        ram_adr      = 16'd0;
        ram_dout     = 8'd0;
        if (state == PUSH) begin
            ram_adr  = sp;
            ram_dout = push_byte(pc_lat, cnt);
        end else if (state == POP) begin
            ram_adr  = sp + 16'd1;
        end
        done         = (state == DONE) && cp2en;
        pc_load      = (state == DONE) && ((op == OP_RET) || (op == OP_RETI)) && cp2en;
        sreg_i_wr_en = (state == DONE) && ((op == OP_IRQ) || (op == OP_RETI)) && cp2en;
        sreg_i_val   = (state == DONE) && (op == OP_RETI);
        pc_out       = pc_q;
    end

endmodule

// File: tb/tb_stack_seq.sv
// Directed bench for stack_seq: one 16-bit-PC and one 22-bit-PC instance, each closed around
// an SP register model and a byte RAM with one-cycle read latency.
module tb_stack_seq;

    logic        cp2 = 1'b0;
    logic        ireset;
    logic        cp2en;
    logic [21:0] pc_in;
    logic [3:0]  st0, st1;   // {irq, call, reti, ret}

    logic [15:0] sp0, sp1;
    logic        sp_wr0, sp_wr1;
    logic [15:0] sp_wdat;
    logic [7:0]  rdat0 = 8'h00, rdat1 = 8'h00;
    logic [7:0]  mem0 [65536];
    logic [7:0]  mem1 [65536];
    int          wcnt0 = 0;

    logic        sp_en0, ndu0, we0, re0, pcl0, siw0, siv0, busy0, done0;
    logic        sp_en1, ndu1, we1, re1, pcl1, siw1, siv1, busy1, done1;
    logic [15:0] adr0, adr1;
    logic [7:0]  dout0, dout1;
    logic [21:0] pco0, pco1;

    int n_chk = 0;
    int n_fail = 0;

    always #5 cp2 = ~cp2;

    stack_seq #(.pc22b(1'b0)) d0 (
        .cp2(cp2), .ireset(ireset), .cp2en(cp2en),
        .start_call(st0[2]), .start_irq(st0[3]), .start_ret(st0[0]), .start_reti(st0[1]),
        .pc_in(pc_in), .spl_in(sp0[7:0]), .sph_in(sp0[15:8]), .ram_din(rdat0),
        .sp_en(sp_en0), .sp_ndown_up(ndu0), .ram_adr(adr0), .ram_dout(dout0),
        .ram_we(we0), .ram_re(re0), .pc_out(pco0), .pc_load(pcl0),
        .sreg_i_wr_en(siw0), .sreg_i_val(siv0), .busy(busy0), .done(done0)
    );

    stack_seq #(.pc22b(1'b1)) d1 (
        .cp2(cp2), .ireset(ireset), .cp2en(cp2en),
        .start_call(st1[2]), .start_irq(st1[3]), .start_ret(st1[0]), .start_reti(st1[1]),
        .pc_in(pc_in), .spl_in(sp1[7:0]), .sph_in(sp1[15:8]), .ram_din(rdat1),
        .sp_en(sp_en1), .sp_ndown_up(ndu1), .ram_adr(adr1), .ram_dout(dout1),
        .ram_we(we1), .ram_re(re1), .pc_out(pco1), .pc_load(pcl1),
        .sreg_i_wr_en(siw1), .sreg_i_val(siv1), .busy(busy1), .done(done1)
    );

    // I/O write has priority over counting, as in the core register file.
    always @(posedge cp2) begin
        if (sp_wr0) sp0 <= sp_wdat;
        else if (sp_en0) sp0 <= ndu0 ? sp0 + 16'd1 : sp0 - 16'd1;
        if (we0) begin
            mem0[adr0] <= dout0;
            wcnt0 <= wcnt0 + 1;
        end
        if (re0) rdat0 <= mem0[adr0];
    end

    always @(posedge cp2) begin
        if (sp_wr1) sp1 <= sp_wdat;
        else if (sp_en1) sp1 <= ndu1 ? sp1 + 16'd1 : sp1 - 16'd1;
        if (we1) mem1[adr1] <= dout1;
        if (re1) rdat1 <= mem1[adr1];
    end

    task automatic cyc();
        @(posedge cp2);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sp_set(input bit d, input logic [15:0] v);
        chk(d ? "sp_write_while_busy1" : "sp_write_while_busy0", d ? busy1 : busy0, 1'b0);
        sp_wdat = v;
        if (d) sp_wr1 = 1'b1; else sp_wr0 = 1'b1;
        cyc();
        sp_wr0 = 1'b0;
        sp_wr1 = 1'b0;
    endtask

    initial begin
        ireset = 1'b0; cp2en = 1'b1; st0 = 4'b0; st1 = 4'b0; pc_in = 22'd0;
        sp_wr0 = 1'b0; sp_wr1 = 1'b0; sp_wdat = 16'd0;
        cyc(); cyc();
        chk("reset_ctl0", {busy0, done0, we0, re0, sp_en0, ndu0, pcl0, siw0, siv0}, 9'd0);
        chk("reset_bus0", {adr0, dout0}, 24'd0);
        chk("reset_pc0", pco0, 22'd0);
        chk("reset_ctl1", {busy1, done1, we1, re1, sp_en1, ndu1, pcl1, siw1, siv1}, 9'd0);
        chk("reset_pc1", pco1, 22'd0);
        ireset = 1'b1;
        cyc();

        // CALL, 16-bit PC; upper pc_in bits must be ignored
        sp_set(1'b0, 16'h10FF);
        pc_in = 22'h3F1234; st0 = 4'b0100; cyc(); st0 = 4'b0;
        chk("call_b0_adr", adr0, 16'h10FF);
        chk("call_b0_dat", dout0, 8'h34);
        chk("call_b0_strb", {we0, re0, sp_en0, ndu0, busy0}, 5'b10101);
        cyc();
        chk("call_b1_adr", adr0, 16'h10FE);
        chk("call_b1_dat", dout0, 8'h12);
        chk("call_b1_strb", {we0, re0, sp_en0, ndu0, busy0}, 5'b10101);
        cyc();
        chk("call_done", {done0, pcl0, siw0, we0, sp_en0, busy0}, 6'b100001);
        cyc();
        chk("call_idle", {done0, busy0}, 2'b00);
        chk("call_sp", sp0, 16'h10FD);
        chk("call_mem", {mem0[16'h10FF], mem0[16'h10FE]}, 16'h3412);

        // RET pops the same bytes back
        st0 = 4'b0001; cyc(); st0 = 4'b0;
        chk("ret_i0_adr", adr0, 16'h10FE);
        chk("ret_i0_strb", {we0, re0, sp_en0, ndu0, busy0}, 5'b01111);
        cyc();
        chk("ret_i1_adr", adr0, 16'h10FF);
        chk("ret_i1_strb", {we0, re0, sp_en0, ndu0, busy0}, 5'b01111);
        cyc();
        chk("ret_capt", {we0, re0, sp_en0, done0, busy0}, 5'b00001);
        cyc();
        chk("ret_done", {done0, pcl0, siw0, busy0}, 4'b1101);
        chk("ret_pc", pco0, 22'h001234);
        cyc();
        chk("ret_idle", {done0, pcl0, busy0}, 3'b000);
        chk("ret_sp", sp0, 16'h10FF);
        chk("ret_pc_hold", pco0, 22'h001234);

        // IRQ entry, 22-bit PC, SP wraps through zero
        sp_set(1'b1, 16'h0001);
        pc_in = 22'h3ABCDE; st1 = 4'b1000; cyc(); st1 = 4'b0;
        chk("irq_b0", {adr1, dout1, we1, sp_en1, ndu1}, {16'h0001, 8'hDE, 3'b110});
        cyc();
        chk("irq_b1", {adr1, dout1, we1, sp_en1, ndu1}, {16'h0000, 8'hBC, 3'b110});
        cyc();
        chk("irq_b2", {adr1, dout1, we1, sp_en1, ndu1}, {16'hFFFF, 8'h3A, 3'b110});
        cyc();
        chk("irq_done", {done1, pcl1, siw1, siv1, busy1}, 5'b10101);
        cyc();
        chk("irq_idle", {busy1, siw1}, 2'b00);
        chk("irq_sp", sp1, 16'hFFFE);
        chk("irq_mem", {mem1[16'hFFFF], mem1[16'h0000], mem1[16'h0001]}, 24'h3ABCDE);

        // RETI
        st1 = 4'b0010; cyc(); st1 = 4'b0;
        chk("reti_i0", {adr1, we1, re1, sp_en1, ndu1}, {16'hFFFF, 4'b0111});
        cyc();
        chk("reti_i1", {adr1, we1, re1, sp_en1, ndu1}, {16'h0000, 4'b0111});
        cyc();
        chk("reti_i2", {adr1, we1, re1, sp_en1, ndu1}, {16'h0001, 4'b0111});
        cyc();
        chk("reti_capt", {we1, re1, sp_en1, done1, busy1}, 5'b00001);
        cyc();
        chk("reti_done", {done1, pcl1, siw1, siv1}, 4'b1111);
        chk("reti_pc", pco1, 22'h3ABCDE);
        cyc();
        chk("reti_idle", {busy1, siw1, pcl1}, 3'b000);
        chk("reti_sp", sp1, 16'h0001);

        // Stall for three cycles between push bytes
        sp_set(1'b0, 16'h2000);
        pc_in = 22'h00ABCD; st0 = 4'b0100; cyc(); st0 = 4'b0;
        chk("stall_b0", {adr0, dout0, we0}, {16'h2000, 8'hCD, 1'b1});
        cyc();
        cp2en = 1'b0; #1;
        chk("stall_strb", {we0, re0, sp_en0, done0, busy0}, 5'b00001);
        cyc(); cyc(); cyc();
        chk("stall_sp", sp0, 16'h1FFF);
        chk("stall_wcnt", wcnt0, 3);
        chk("stall_hold", {adr0, dout0, we0}, {16'h1FFF, 8'hAB, 1'b0});
        cp2en = 1'b1; #1;
        chk("stall_resume", {adr0, dout0, we0, sp_en0}, {16'h1FFF, 8'hAB, 2'b11});
        cyc();
        chk("stall_done", {done0, busy0}, 2'b11);
        cyc();
        chk("stall_sp_end", sp0, 16'h1FFE);
        chk("stall_mem", {mem0[16'h2000], mem0[16'h1FFF]}, 16'hCDAB);
        chk("stall_wcnt_end", wcnt0, 4);

        // Priority: call beats ret; irq beats call and reti
        sp_set(1'b0, 16'h3000);
        pc_in = 22'h000555; st0 = 4'b0101; cyc(); st0 = 4'b0;
        chk("prio_call", {adr0, dout0, we0, re0, ndu0}, {16'h3000, 8'h55, 3'b100});
        cyc(); cyc();
        chk("prio_call_done", {done0, pcl0, siw0}, 3'b100);
        cyc();
        sp_set(1'b1, 16'h0100);
        st1 = 4'b1110; cyc(); st1 = 4'b0;
        chk("prio_irq", {we1, re1}, 2'b10);
        cyc(); cyc(); cyc();
        chk("prio_irq_done", {done1, siw1, siv1, pcl1}, 4'b1100);
        cyc();

        // Reset in the middle of a pop, then a fresh pop
        sp_set(1'b1, 16'hFFFE);
        st1 = 4'b0001; cyc(); st1 = 4'b0;
        chk("rst_i0", {adr1, re1}, {16'hFFFF, 1'b1});
        cyc();
        chk("rst_i1", {adr1, re1}, {16'h0000, 1'b1});
        ireset = 1'b0; #1;
        chk("rst_ctl", {busy1, re1, sp_en1, ndu1, done1, pcl1, siw1, siv1}, 8'd0);
        chk("rst_bus", {adr1, dout1}, 24'd0);
        chk("rst_pc", pco1, 22'd0);
        cyc();
        chk("rst_sp", sp1, 16'hFFFF);
        ireset = 1'b1;
        sp_set(1'b1, 16'hFFFE);
        st1 = 4'b0001; cyc(); st1 = 4'b0;
        chk("rst_new_i0", {adr1, re1, busy1}, {16'hFFFF, 2'b11});
        cyc(); cyc(); cyc(); cyc();
        chk("rst_new_done", {done1, pcl1, siw1}, 3'b110);
        chk("rst_new_pc", pco1, 22'h3ABCDE);
        cyc();
        chk("rst_new_sp", sp1, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Multi-cycle stack engine for the AVR core. It drives the SP count-enable/direction pair of the core I/O register file and the data-RAM port to push and pop return addresses.
- Covers CALL/RCALL/ICALL (push PC), interrupt entry (push PC, clear I), RET (pop PC) and RETI (pop PC, set I).
- Sits between the instruction decoder/IRQ logic and the data-memory mux. It reads the live SPH:SPL and returns the popped PC to the PC unit.

Parameters:
pc22b, 0, 0: PC is 16 bits, 2 stack bytes. 1: PC is 22 bits, 3 stack bytes.

Ports:
cp2  in  1  core clock
ireset  in  1  reset, asynchronous, active-low
cp2en  in  1  clock enable; FSM and all strobes frozen when low
start_call  in  1  push request (1-cycle pulse)
start_irq  in  1  interrupt-entry push request
start_ret  in  1  pop request
start_reti  in  1  pop request plus I-flag set
pc_in  in  22  return address to push; bits [21:16] ignored when pc22b=0
spl_in  in  8  current SPL from the I/O register file
sph_in  in  8  current SPH from the I/O register file
ram_din  in  8  RAM read data, valid 1 cycle after ram_re
sp_en  out  1  SP count enable
sp_ndown_up  out  1  0 = SP decrement, 1 = SP increment
ram_adr  out  16  RAM byte address
ram_dout  out  8  RAM write data
ram_we  out  1  RAM write strobe
ram_re  out  1  RAM read strobe
pc_out  out  22  popped PC, registered
pc_load  out  1  1-cycle pulse: pc_out valid
sreg_i_wr_en  out  1  pulse to SREG bit 7 write enable
sreg_i_val  out  1  value for SREG bit 7
busy  out  1  FSM not IDLE
done  out  1  1-cycle completion pulse

Behaviour:
- Reset (async, ireset=0): state=IDLE. All outputs 0, including pc_out. Byte counter and capture registers cleared. Reset mid-sequence aborts immediately; SP keeps whatever value it already reached.
- NB = 2 if pc22b=0, otherwise 3. SP is 16 bits {sph_in,spl_in}. All SP arithmetic wraps modulo 2^16.
- States: IDLE, PUSH, POP, CAPT, DONE. The FSM and the byte counter advance only when cp2en=1.
- IDLE:
  - Starts are sampled only when cp2en=1 and in IDLE; starts while busy are ignored.
  - Priority when starts coincide: start_irq > start_call > start_reti > start_ret.
  - Latch the operation type, and latch pc_in for a push. Go to PUSH or POP, byte counter = 0.
- PUSH, one byte per cycle:
  - ram_adr = SP, ram_we=1, sp_en=1, sp_ndown_up=0.
  - ram_dout order: byte0 = pc[7:0], byte1 = pc[15:8], byte2 = pc[21:16] zero-extended.
  - SP post-decrements in the register file, so the next cycle sees the new SP.
  - After byte NB-1, go to DONE.
- POP, one issue per cycle:
  - ram_adr = SP+1, ram_re=1, sp_en=1, sp_ndown_up=1.
  - ram_din for issue k is captured in the following cycle.
  - Byte order returned: high byte first (byte2 if pc22b), then byte1, then byte0.
  - After issue NB-1, go to CAPT.
- CAPT:
  - Capture the last byte (byte0); no strobes.
  - Assemble pc_out; bits [21:16] = 0 when pc22b=0. Go to DONE.
- DONE, one cycle:
  - done=1, then go to IDLE.
  - pc_load=1 for ret/reti.
  - sreg_i_wr_en=1 for irq (sreg_i_val=0) and reti (sreg_i_val=1).
- Strobe gating: ram_we, ram_re, sp_en, done, pc_load and sreg_i_wr_en are all ANDed with cp2en. With cp2en=0 the state holds and nothing is written or counted.
- Read latency across stalls: a capture pending from the last issue completes on the next cp2en=1 cycle. RAM holds ram_din while cp2en=0.
- Latency, start edge k:
  - push done at k+NB+1.
  - pop pc_load/done at k+NB+2.
- busy=1 in every non-IDLE state.
- SP access rule: the decoder must not issue an I/O write to SPL/SPH while busy=1. The register file gives iowe priority, which would corrupt the sequence; the bench checks this as an assertion.
- No output is combinationally dependent on start_*. Outputs derive from state, the latched PC, spl_in/sph_in and cp2en.

Test Plan:
- Call, pc22b=0, SP=0x10FF, pc_in=0x1234 -> writes 0x34@0x10FF then 0x12@0x10FE, SP=0x10FD, done at k+3, no sreg pulse.
- Ret from the above state, RAM returning stored bytes -> reads @0x10FE then @0x10FF, pc_out=0x001234, pc_load and done at k+4, SP=0x10FF.
- Irq, pc22b=1, SP=0x0001, pc_in=0x3ABCDE:
  - -> writes 0xDE@0x0001, 0xBC@0x0000, 0x3A@0xFFFF (wrap), SP=0xFFFE.
  - -> sreg_i_wr_en=1 with sreg_i_val=0 in DONE.
- Reti, pc22b=1, from the above state -> reads @0xFFFF, 0x0000, 0x0001; pc_out=0x3ABCDE; sreg_i_val=1 pulse; SP=0x0001.
- Stall and priority:
  - cp2en low for 3 cycles mid-push -> no extra writes, SP unchanged during the stall, resumes correctly.
  - start_call and start_ret together -> call executes.
- Reset mid-pop: ireset low after the first issue -> all outputs 0 at once; a new start_ret after reset begins a fresh pop.
